decode: RTL and testbench

Instruction-decode stage of the LC3 core, directly downstream of `fetch`. It consumes the instruction word returned by block RAM for the address `fetch` placed on `addr_out`, and waits out the RAM read latency. It then latches the word into the instruction register (IR) and presents decoded fields to the execute and branch logic. This includes the `opCode`, `offset`, `br_nzp` and register indices that `fetch` later needs for PC redirection.

---
 rtl/decode.sv | 145 ++++++++++++++
 tb/tb_decode.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/decode.sv
// LC3 instruction-decode stage: waits out the block-RAM read latency, latches the
// instruction word into IR and presents combinational decoded fields to later stages.
module decode #(
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        decode_start,
   input  logic [15:0] instr_in,
   output logic        busy,
   output logic        decode_done,
   output logic [15:0] ir,
   output logic [3:0]  opCode_out,
   output logic [2:0]  dr_out,
   output logic [2:0]  sr1_out,
   output logic [2:0]  sr2_out,
   output logic        imm_mode,
   output logic [2:0]  br_nzp,
   output logic [15:0] imm5_sext,
   output logic [15:0] offset6_sext,
   output logic [8:0]  offset_out,
   output logic [15:0] offset9_sext,
   output logic [15:0] offset11_sext,
   output logic [7:0]  trapvect,
   output logic        reg_write,
   output logic        set_cc,
   output logic        illegal
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [1:0] CntLoad = 2'(MEM_LATENCY - 1);

   localparam logic [3:0] OpBr   = 4'b0000;
   localparam logic [3:0] OpAdd  = 4'b0001;
   localparam logic [3:0] OpLd   = 4'b0010;
   localparam logic [3:0] OpSt   = 4'b0011;
   localparam logic [3:0] OpJsr  = 4'b0100;
   localparam logic [3:0] OpAnd  = 4'b0101;
   localparam logic [3:0] OpLdr  = 4'b0110;
   localparam logic [3:0] OpStr  = 4'b0111;
   localparam logic [3:0] OpRti  = 4'b1000;
   localparam logic [3:0] OpNot  = 4'b1001;
   localparam logic [3:0] OpLdi  = 4'b1010;
   localparam logic [3:0] OpSti  = 4'b1011;
   localparam logic [3:0] OpJmp  = 4'b1100;
   localparam logic [3:0] OpRes  = 4'b1101;
   localparam logic [3:0] OpLea  = 4'b1110;
   localparam logic [3:0] OpTrap = 4'b1111;

   state_e      state_q;
   logic [1:0]  cnt_q;
   logic [15:0] ir_q;
   logic        busy_q;
   logic        done_q;

   // busy/decode_done are registered alongside the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         ir_q    <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (decode_start) begin
                  state_q <= StWait;
                  cnt_q   <= CntLoad;
                  busy_q  <= 1'b1;
               end
            end
            StWait: begin
               if (cnt_q == 2'd0) begin
                  ir_q    <= instr_in;
                  state_q <= StDone;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            StDone: begin
               done_q <= 1'b0;
               if (decode_start) begin
                  state_q <= StWait;
                  cnt_q   <= CntLoad;
               end else begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= StIdle;
               cnt_q   <= 2'd0;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy        = busy_q;
   assign decode_done = done_q;
   assign ir          = ir_q;

   assign opCode_out    = ir_q[15:12];
   assign dr_out        = ir_q[11:9];
   assign sr1_out       = ir_q[8:6];
   assign sr2_out       = ir_q[2:0];
   assign imm_mode      = ir_q[5];
   assign br_nzp        = ir_q[11:9];
   assign imm5_sext     = {{11{ir_q[4]}}, ir_q[4:0]};
   assign offset6_sext  = {{10{ir_q[5]}}, ir_q[5:0]};
   assign offset_out    = ir_q[8:0];
   assign offset9_sext  = {{7{ir_q[8]}}, ir_q[8:0]};
   assign offset11_sext = {{5{ir_q[10]}}, ir_q[10:0]};
   assign trapvect      = ir_q[7:0];

   // JSR/JSRR and TRAP write R7; LEA writes a register but leaves the CCs alone.
   always_comb begin
      reg_write = 1'b0;
      set_cc    = 1'b0;
      illegal   = 1'b0;
      case (ir_q[15:12])
         OpAdd, OpAnd, OpNot, OpLd, OpLdi, OpLdr: begin
            reg_write = 1'b1;
            set_cc    = 1'b1;
         end
         OpJsr, OpLea, OpTrap: begin
            reg_write = 1'b1;
         end
         OpRti, OpRes: begin
            illegal = 1'b1;
         end
         OpBr, OpSt, OpStr, OpSti, OpJmp: begin
            reg_write = 1'b0;
         end
         default: begin
            reg_write = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_decode.sv
// Directed bench for decode: a reference model fills a scoreboard at each start pulse and
// a monitor checks fields and pulse timing whenever decode_done fires.
module tb_decode;

   localparam int unsigned L = 2;
   localparam logic [15:0] RwMask = 16'hC676;
   localparam logic [15:0] CcMask = 16'h0666;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        decode_start = 1'b0;
   logic [15:0] instr_in = 16'h0000;
   logic        busy, decode_done, imm_mode, reg_write, set_cc, illegal;
   logic [15:0] ir, imm5_sext, offset6_sext, offset9_sext, offset11_sext;
   logic [3:0]  opCode_out;
   logic [2:0]  dr_out, sr1_out, sr2_out, br_nzp;
   logic [8:0]  offset_out;
   logic [7:0]  trapvect;

   decode #(.MEM_LATENCY(L)) dut (
      .clk(clk), .rst_n(rst_n), .decode_start(decode_start), .instr_in(instr_in),
      .busy(busy), .decode_done(decode_done), .ir(ir), .opCode_out(opCode_out),
      .dr_out(dr_out), .sr1_out(sr1_out), .sr2_out(sr2_out), .imm_mode(imm_mode),
      .br_nzp(br_nzp), .imm5_sext(imm5_sext), .offset6_sext(offset6_sext),
      .offset_out(offset_out), .offset9_sext(offset9_sext), .offset11_sext(offset11_sext),
      .trapvect(trapvect), .reg_write(reg_write), .set_cc(set_cc), .illegal(illegal)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int last_done_cyc = 0;
   logic [15:0] exp_instr_q[$];
   int          exp_cyc_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Monitor: every decode_done must match the oldest outstanding start.
   always @(negedge clk) begin
      if (rst_n && decode_done) begin
         logic [15:0] w;
         logic [3:0]  op;
         int          ec;
         done_cnt++;
         last_done_cyc = cyc;
         chk("done_expected", 16'(exp_instr_q.size() != 0), 16'h0001);
         if (exp_instr_q.size() != 0) begin
            w  = exp_instr_q.pop_front();
            ec = exp_cyc_q.pop_front();
            op = w[15:12];
            chk("done_cycle", 16'(cyc), 16'(ec));
            chk("ir", ir, w);
            chk("opcode", 16'(opCode_out), 16'(op));
            chk("dr", 16'(dr_out), 16'(w[11:9]));
            chk("sr1", 16'(sr1_out), 16'(w[8:6]));
            chk("sr2", 16'(sr2_out), 16'(w[2:0]));
            chk("imm_mode", 16'(imm_mode), 16'(w[5]));
            chk("br_nzp", 16'(br_nzp), 16'(w[11:9]));
            chk("imm5_sext", imm5_sext, 16'($signed(w[4:0])));
            chk("offset6_sext", offset6_sext, 16'($signed(w[5:0])));
            chk("offset_out", 16'(offset_out), 16'(w[8:0]));
            chk("offset9_sext", offset9_sext, 16'($signed(w[8:0])));
            chk("offset11_sext", offset11_sext, 16'($signed(w[10:0])));
            chk("trapvect", 16'(trapvect), 16'(w[7:0]));
            chk("illegal", 16'(illegal), 16'(op == 4'd8 || op == 4'd13));
            chk("reg_write", 16'(reg_write), 16'(RwMask[op]));
            chk("set_cc", 16'(set_cc), 16'(CcMask[op]));
            chk("busy_in_done", 16'(busy), 16'h0001);
         end
      end
   end

   // Called at a negedge; the pulse is sampled at the following posedge.
   task automatic start(input logic [15:0] w);
      instr_in     = w;
      decode_start = 1'b1;
      exp_instr_q.push_back(w);
      exp_cyc_q.push_back(cyc + 1 + int'(L));
      @(negedge clk);
      decode_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      logic hit = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (decode_done) begin
            hit = 1'b1;
            break;
         end
      end
      chk({tag, "_timeout"}, 16'(hit), 16'h0001);
   endtask

   initial begin
      int first_done;
      int cnt_before;
      logic [15:0] ir_before;

      // Reset values
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ir", ir, 16'h0000);
      chk("rst_busy", 16'(busy), 16'h0000);
      chk("rst_done", 16'(decode_done), 16'h0000);
      chk("rst_fields", {opCode_out, dr_out, sr1_out, sr2_out, imm_mode, reg_write, set_cc},
          16'h0000);
      chk("rst_flags", 16'({illegal, br_nzp, offset_out}), 16'h0000);
      chk("rst_sext", imm5_sext | offset6_sext | offset9_sext | offset11_sext
          | 16'(trapvect), 16'h0000);

      // ADD R1,R1,#1; IR must hold through WAIT
      start(16'h1261);
      chk("wait_busy", 16'(busy), 16'h0001);
      chk("wait_done_low", 16'(decode_done), 16'h0000);
      chk("wait_ir_hold", ir, 16'h0000);
      wait_done("add");
      chk("add_imm5", imm5_sext, 16'h0001);
      chk("add_reg_write", 16'(reg_write), 16'h0001);
      chk("add_set_cc", 16'(set_cc), 16'h0001);
      @(negedge clk);
      chk("idle_busy", 16'(busy), 16'h0000);
      chk("idle_done", 16'(decode_done), 16'h0000);
      chk("idle_ir_hold", ir, 16'h1261);

      // BRzp with negative offset
      start(16'h07FF);
      wait_done("br");
      chk("br_nzp", 16'(br_nzp), 16'h0003);
      chk("br_off9", offset9_sext, 16'hFFFF);
      chk("br_reg_write", 16'(reg_write), 16'h0000);
      @(negedge clk);

      // LDR R2,R3,#-32
      start(16'h64E0);
      wait_done("ldr");
      chk("ldr_off6", offset6_sext, 16'hFFE0);
      @(negedge clk);

      // Reserved opcode, then back-to-back restart from DONE with AND
      start(16'hD000);
      wait_done("res");
      chk("res_illegal", 16'(illegal), 16'h0001);
      chk("res_reg_write", 16'(reg_write), 16'h0000);
      first_done = cyc;
      start(16'h5020);
      chk("b2b_busy", 16'(busy), 16'h0001);
      wait_done("b2b");
      chk("b2b_gap", 16'(cyc - first_done), 16'(L + 1));
      chk("b2b_ir", ir, 16'h5020);
      @(negedge clk);

      // Second start during WAIT is ignored
      cnt_before = done_cnt;
      start(16'hE3FE);
      instr_in     = 16'hF025;
      decode_start = 1'b1;
      @(negedge clk);
      decode_start = 1'b0;
      instr_in     = 16'hE3FE;
      repeat (8) @(negedge clk);
      chk("ignored_start_count", 16'(done_cnt - cnt_before), 16'h0001);
      chk("ignored_start_ir", ir, 16'hE3FE);

      // TRAP for coverage of R7 writers
      start(16'hF025);
      wait_done("trap");
      @(negedge clk);

      // Reset aborts a pending decode
      cnt_before = done_cnt;
      start(16'h1261);
      rst_n = 1'b0;
      void'(exp_instr_q.pop_back());
      void'(exp_cyc_q.pop_back());
      @(negedge clk);
      chk("abort_busy", 16'(busy), 16'h0000);
      chk("abort_ir", ir, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("abort_no_done", 16'(done_cnt - cnt_before), 16'h0000);
      chk("abort_ir_after", ir, 16'h0000);
      chk("abort_idle", 16'(busy), 16'h0000);
      chk("queue_empty", 16'(exp_instr_q.size()), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
